// File: rtl/mandel_pkg.sv
// mandel_pkg
//   Types and default field widths shared by the Mandelbrot pixel path
//   (pixel FIFO -> line reorder -> video out).
//   Contents:
//     X_WIDTH_DFLT / ITER_WIDTH_DFLT : default x and depth field widths
//     pixel_word_t                   : FIFO word layout {x, depth}
//     rgb_t                          : RGB888 pixel
//     buf_state_t                    : line-buffer life cycle
package mandel_pkg;

    localparam int X_WIDTH_DFLT    = 10;
    localparam int ITER_WIDTH_DFLT = 10;

    typedef struct packed {
        logic [X_WIDTH_DFLT-1:0]    x;
        logic [ITER_WIDTH_DFLT-1:0] depth;
    } pixel_word_t;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/pixel_color_map.sv
// pixel_color_map
//   Combinational depth -> RGB888 colour map. Pixels at or above MAX_ITER
//   are inside the set and always map to black.
//   Build option: PIXEL_PALETTE_LUT_EN selects a 256-entry palette ROM
//   indexed by depth[7:0]; otherwise the low depth byte is used as grey.
//   Ports:
//     depth_i : iteration count of the pixel
//     rgb_o   : mapped colour {r, g, b}
module pixel_color_map
    import mandel_pkg::*;
#(
    parameter int ITER_WIDTH = ITER_WIDTH_DFLT,
    parameter int MAX_ITER   = 255
) (
    input  logic [ITER_WIDTH-1:0] depth_i,
    output rgb_t                  rgb_o
);

    logic [7:0] idx;
    rgb_t       base;

    assign idx = depth_i[7:0];

`ifdef PIXEL_PALETTE_LUT_EN
    // Palette: red ramps up, green ramps at twice the rate, blue ramps down.
    function automatic rgb_t palette_entry(input logic [7:0] i);
        return {i, {i[6:0], 1'b0}, ~i};
    endfunction

    rgb_t rom [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = palette_entry(8'(i));
    end

    assign base = rom[idx];
`else
    assign base = {idx, idx, idx};
`endif

    assign rgb_o = (depth_i >= ITER_WIDTH'(MAX_ITER)) ? 24'h000000 : base;

endmodule

// File: rtl/pixel_line_reorder.sv
// pixel_line_reorder
//   Collects out-of-order pixels from the multi-engine pixel FIFO into a
//   ping-pong pair of line buffers indexed by x, then streams each
//   completed line in ascending x as AXI4-Stream video (SOF on tuser,
//   EOL on tlast).
//   Build option: PIXEL_PALETTE_LUT_EN (palette colour map, see
//   pixel_color_map).
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     fifo_empty   : pixel FIFO empty
//     fifo_data    : FIFO read data {x, depth}, valid one cycle after rd_en
//     fifo_rd_en   : FIFO read request
//     fill_y       : line currently being collected
//     fill_busy    : fill side is not stalled waiting for a free buffer
//     m_tdata/m_tvalid/m_tready/m_tuser/m_tlast : video stream
//     err_sticky   : out-of-range or duplicate x seen since reset
module pixel_line_reorder
    import mandel_pkg::*;
#(
    parameter int X_WIDTH    = X_WIDTH_DFLT,
    parameter int ITER_WIDTH = ITER_WIDTH_DFLT,
    parameter int DATA_WIDTH = 20,
    parameter int LINE_WIDTH = 640,
    parameter int NUM_LINES  = 480,
    parameter int MAX_ITER   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    output logic                         fifo_rd_en,
    output logic [$clog2(NUM_LINES)-1:0] fill_y,
    output logic                         fill_busy,
    output logic [23:0]                  m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tuser,
    output logic                         m_tlast,
    output logic                         err_sticky
);

    localparam int XI_W  = $clog2(LINE_WIDTH);
    localparam int Y_W   = $clog2(NUM_LINES);
    localparam int CNT_W = $clog2(LINE_WIDTH + 1);
    localparam int AW    = XI_W + 1;

    // Fill side state
    buf_state_t            state_q [2];
    buf_state_t            state_d [2];
    logic [LINE_WIDTH-1:0] valid_q [2];
    logic [LINE_WIDTH-1:0] valid_d [2];
    logic                  fill_sel_q, fill_sel_d;
    logic [Y_W-1:0]        fill_y_q, fill_y_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_pend_q;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  err_q, err_d;

    // Drain side state (read issue pointer)
    logic                  drain_sel_q, drain_sel_d;
    logic [XI_W-1:0]       drain_x_q, drain_x_d;
    logic [Y_W-1:0]        drain_y_q, drain_y_d;

    // Drain pipeline: s1 = line RAM read, out = output register
    logic                  s1_vld_q, s1_sel_q, s1_user_q, s1_last_q;
    logic [ITER_WIDTH-1:0] s1_depth_q;
    rgb_t                  s1_rgb;
    logic                  out_vld_q, out_sel_q, out_user_q, out_last_q;
    rgb_t                  out_data_q;

    logic [ITER_WIDTH-1:0] mem [2**AW];

    // Incoming word: the holding register takes priority over the FIFO.
    logic                  in_vld, writable, wr_try, bad_x, dup, wr_en, complete;
    logic [DATA_WIDTH-1:0] in_word;
    logic [X_WIDTH-1:0]    in_x;
    logic [XI_W-1:0]       in_xi;
    logic [ITER_WIDTH-1:0] in_depth;
    logic                  advance, issue, issue_last, hs_last;

    assign in_word  = hold_vld_q ? hold_q : fifo_data;
    assign in_x     = in_word[DATA_WIDTH-1:ITER_WIDTH];
    assign in_xi    = in_x[XI_W-1:0];
    assign in_depth = in_word[ITER_WIDTH-1:0];
    assign in_vld   = rd_pend_q || hold_vld_q;
    // An EMPTY buffer may already take a word; only FULL blocks the fill.
    assign writable = (state_q[fill_sel_q] != BUF_FULL);
    assign wr_try   = in_vld && writable;
    assign bad_x    = ({1'b0, in_x} >= (X_WIDTH + 1)'(LINE_WIDTH));
    assign dup      = valid_q[fill_sel_q][in_xi];
    assign wr_en    = wr_try && !bad_x && !dup;
    assign complete = wr_en && (count_q == CNT_W'(LINE_WIDTH - 1));

    // Stop reading on the completing write so nothing is requested past the line.
    assign fifo_rd_en = !fifo_empty && (state_q[fill_sel_q] == BUF_FILLING)
                        && !complete && !hold_vld_q;

    assign advance    = !out_vld_q || m_tready;
    assign issue      = advance && (state_q[drain_sel_q] == BUF_FULL);
    assign issue_last = (drain_x_q == XI_W'(LINE_WIDTH - 1));
    assign hs_last    = out_vld_q && m_tready && out_last_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        fill_sel_d  = fill_sel_q;
        fill_y_d    = fill_y_q;
        count_d     = count_q;
        hold_vld_d  = hold_vld_q;
        err_d       = err_q;
        drain_sel_d = drain_sel_q;
        drain_x_d   = drain_x_q;
        drain_y_d   = drain_y_q;

        if (state_q[fill_sel_q] == BUF_EMPTY) begin
            state_d[fill_sel_q] = BUF_FILLING;
        end
        if (wr_try && (bad_x || dup)) begin
            err_d = 1'b1;
        end
        if (wr_en) begin
            valid_d[fill_sel_q][in_xi] = 1'b1;
            count_d = count_q + 1'b1;
        end
        // A word arriving while the fill buffer is FULL waits in the holding register.
        if (hold_vld_q) begin
            hold_vld_d = !writable;
        end else begin
            hold_vld_d = rd_pend_q && !writable;
        end
        if (complete) begin
            state_d[fill_sel_q] = BUF_FULL;
            fill_sel_d = !fill_sel_q;
            count_d    = '0;
            fill_y_d   = (fill_y_q == Y_W'(NUM_LINES - 1)) ? '0 : fill_y_q + 1'b1;
        end

        if (issue) begin
            if (issue_last) begin
                drain_x_d   = '0;
                drain_sel_d = !drain_sel_q;
                drain_y_d   = (drain_y_q == Y_W'(NUM_LINES - 1)) ? '0 : drain_y_q + 1'b1;
            end else begin
                drain_x_d = drain_x_q + 1'b1;
            end
        end
        // The buffer being released is FULL, so it never collides with the fill updates above.
        if (hs_last) begin
            state_d[out_sel_q] = BUF_EMPTY;
            valid_d[out_sel_q] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q[0]  <= BUF_EMPTY;
            state_q[1]  <= BUF_EMPTY;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            fill_sel_q  <= 1'b0;
            fill_y_q    <= '0;
            count_q     <= '0;
            rd_pend_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            drain_sel_q <= 1'b0;
            drain_x_q   <= '0;
            drain_y_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_user_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_sel_q   <= 1'b0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            fill_sel_q  <= fill_sel_d;
            fill_y_q    <= fill_y_d;
            count_q     <= count_d;
            rd_pend_q   <= fifo_rd_en;
            hold_vld_q  <= hold_vld_d;
            err_q       <= err_d;
            drain_sel_q <= drain_sel_d;
            drain_x_q   <= drain_x_d;
            drain_y_q   <= drain_y_d;
            // Both drain stages move together; the output holds while stalled.
            if (advance) begin
                s1_vld_q  <= issue;
                s1_sel_q  <= drain_sel_q;
                s1_user_q <= (drain_x_q == '0) && (drain_y_q == '0);
                s1_last_q <= issue_last;
                out_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    out_sel_q  <= s1_sel_q;
                    out_user_q <= s1_user_q;
                    out_last_q <= s1_last_q;
                    out_data_q <= s1_rgb;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend_q && !hold_vld_q && !writable) begin
            hold_q <= fifo_data;
        end
        if (wr_en) begin
            mem[{fill_sel_q, in_xi}] <= in_depth;
        end
        if (issue) begin
            s1_depth_q <= mem[{drain_sel_q, drain_x_q}];
        end
    end

    pixel_color_map #(
        .ITER_WIDTH (ITER_WIDTH),
        .MAX_ITER   (MAX_ITER)
    ) u_color_map (
        .depth_i (s1_depth_q),
        .rgb_o   (s1_rgb)
    );

    assign fill_y     = fill_y_q;
    assign fill_busy  = (state_q[fill_sel_q] != BUF_FULL);
    assign m_tdata    = out_data_q;
    assign m_tvalid   = out_vld_q;
    assign m_tuser    = out_user_q;
    assign m_tlast    = out_last_q;
    assign err_sticky = err_q;

endmodule

// File: doc/pixel_line_reorder.md
Name: pixel_line_reorder

Overview:
- Consumes completed pixels from the multi-engine pixel FIFO. Engines finish out of x-order, so entries arrive unordered.
- Scatters each pixel into a ping-pong pair of line buffers indexed by x.
- Once a line is complete, streams it out in ascending x order as colour-mapped AXI4-Stream video, with SOF on tuser and EOL on tlast.
- Sits between pixel_fifo and the video output / VDMA.

Parameters:
- X_WIDTH, 10, bit width of the x field.
- ITER_WIDTH, 10, bit width of the depth (iteration count) field.
- DATA_WIDTH, 20, FIFO word width; must equal X_WIDTH+ITER_WIDTH.
- LINE_WIDTH, 640, pixels per line.
- NUM_LINES, 480, lines per frame.
- MAX_ITER, 255, depth value that marks a pixel inside the set.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fifo_empty  in  1  pixel FIFO empty.
- fifo_data  in  DATA_WIDTH  pixel FIFO registered read data; fields {x[DATA_WIDTH-1:ITER_WIDTH], depth[ITER_WIDTH-1:0]}.
- fifo_rd_en  out  1  pixel FIFO read request.
- fill_y  out  $clog2(NUM_LINES)  line currently being collected.
- fill_busy  out  1  fill buffer is collecting (not waiting for a free buffer).
- m_tdata  out  24  RGB888 pixel.
- m_tvalid  out  1  AXI-Stream valid.
- m_tready  in  1  AXI-Stream ready.
- m_tuser  out  1  start of frame (first pixel of line 0).
- m_tlast  out  1  end of line (x = LINE_WIDTH-1).
- err_sticky  out  1  set on any x >= LINE_WIDTH or duplicate x within a line; cleared only by reset.

Behaviour:
- Reset values: fifo_rd_en=0, fill_y=0, fill_busy=1, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, err_sticky=0.
- Reset also clears both buffer states to EMPTY, fill_sel=0, drain_sel=0, drain_y=0, all valid bitmaps, and all counters. Reset mid-line or mid-stream discards all data; the next streamed pixel carries tuser=1.
- Buffer states, per buffer: EMPTY -> FILLING -> FULL -> EMPTY.
  - FILLING -> FULL when the filled count reaches LINE_WIDTH.
  - FULL -> EMPTY on the tlast handshake of that buffer.
- Read side:
  - fifo_rd_en = !fifo_empty && fill buffer FILLING.
  - rd_pend <= fifo_rd_en. fifo_data is consumed in the cycle after rd_pend is set (1-cycle FIFO latency).
- Write of a consumed word:
  - x >= LINE_WIDTH: drop the word, set err_sticky.
  - valid[x] already set: drop the word, set err_sticky; count is unchanged.
  - Otherwise: write depth to buf[fill_sel][x], set valid[x], increment count.
- Completion:
  - On the write that makes count == LINE_WIDTH, mark the buffer FULL and deassert fifo_rd_en in the same cycle.
  - A word already in flight (rd_pend) for the next line is written into the other buffer if it is EMPTY; otherwise it is held in a 1-entry holding register until that buffer frees.
  - fill_sel then toggles; fill_y increments and wraps NUM_LINES-1 -> 0.
  - fill_busy=0 while waiting for a free buffer.
- Drain pipeline:
  - Two stages: sync-read line RAM, then output register.
  - advance = !m_tvalid || m_tready. Both stages advance together; there are no bubbles in steady state.
  - The first pixel of a FULL buffer reaches m_tvalid 2 cycles after FULL.
  - m_tdata/m_tuser/m_tlast are held stable while m_tvalid && !m_tready.
  - tlast = (drain_x == LINE_WIDTH-1). tuser = (drain_x == 0 && drain_y == 0).
  - On the tlast handshake: clear that buffer's valid bitmap, mark it EMPTY, toggle drain_sel, and increment drain_y (wraps NUM_LINES-1 -> 0).
- Colour map (default):
  - depth >= MAX_ITER -> 0x000000.
  - Otherwise greyscale {g,g,g} with g = depth[7:0].
- Simultaneous events: the drain side freeing a buffer and the fill side completing a line in the same cycle is legal; the freed buffer is available to the fill side the next cycle.

Optional Feature:
- Macro PIXEL_PALETTE_LUT_EN.
- Defined: a 256-entry x 24-bit palette ROM indexed by depth[7:0] replaces the greyscale map; depth >= MAX_ITER still maps to black. ROM read sits in the RAM stage, so latency is unchanged.
- Undefined: greyscale map only; no ROM is instantiated.

Decomposition:
- Package mandel_pkg:
  - X_WIDTH and ITER_WIDTH defaults.
  - pixel_word_t packed struct {x, depth}.
  - rgb_t typedef.
  - buf_state_t enum {BUF_EMPTY, BUF_FILLING, BUF_FULL}.
- Sub-module pixel_color_map: combinational depth -> rgb_t, containing the macro-selected LUT/greyscale.

Test Plan (LINE_WIDTH=8, NUM_LINES=2, MAX_ITER=255):
- Push x order 7,3,0,5,1,6,2,4 with depth=x+10, m_tready=1 -> 8 beats, x=0..7, m_tdata grey 10..17; tuser on beat 0; tlast on beat 7.
- Two full lines pushed back-to-back while m_tready=0 -> fill_busy=0 after line 2; after 20 stall cycles raise m_tready -> 16 beats; tuser only on the first beat of line 0; the third line gets tuser again (y wrap).
- Toggle m_tready every cycle mid-line -> data stable during stalls, no lost or duplicated beats, order preserved.
- Inject x=9, then a duplicate x=3 -> err_sticky=1; the line still completes with the first x=3 value; the stream is 8 beats.
- Depth=255 at x=2 -> beat 2 m_tdata=0x000000; with PIXEL_PALETTE_LUT_EN, beat 5 (depth 15) equals palette[15].
- Assert reset after 4 beats of a line -> all outputs return to reset values; the next full line streams with tuser=1.
